// File: rtl/heat_row_painter.sv
// Latches one grid row of Q4.27 node amplitudes and paints each node as a
// CELL_W x CELL_H RGB332 heat-map block through the pixel-write port.
module heat_row_painter #(
  parameter int N_COLS   = 30,
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 8,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic                  row_valid,
  input  logic [7:0]            row_index,
  input  logic [7:0]            height,
  input  logic [32*N_COLS-1:0]  node_flat,
  output logic                  row_ready,
  output logic                  pix_we,
  output logic [9:0]            pix_x,
  output logic [9:0]            pix_y,
  output logic [7:0]            pix_color,
  input  logic                  pix_ack,
  output logic                  frame_done
);

  typedef enum logic [1:0] {IDLE, PAINT, FINISH} state_t;

  localparam logic [9:0] LAST_COL = 10'(N_COLS - 1);
  localparam logic [9:0] LAST_PX  = 10'(CELL_W - 1);
  localparam logic [9:0] LAST_PY  = 10'(CELL_H - 1);

  state_t                 state, state_nx;
  logic [32*N_COLS-1:0]   row_q;
  logic [7:0]             row_idx_q;
  logic [9:0]             col, px, py;
  logic                   adv, last_pix;
  logic [31:19]           amp;
  logic [7:0]             idx;
  logic [7:0]             color;

  assign adv      = (state == PAINT) && pix_ack;
  assign last_pix = (col == LAST_COL) && (px == LAST_PX) && (py == LAST_PY);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    row_ready  = 1'b0;
    pix_we     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        row_ready = 1'b1;
        if (row_valid) state_nx = PAINT;
      end
      PAINT: begin
        pix_we = 1'b1;
        if (adv && last_pix) state_nx = FINISH;
      end
      FINISH: begin
        frame_done = (row_idx_q == height);
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Scan counters: px fastest, then py, then col; all wrap to 0 after the last pixel.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      row_idx_q <= '0;
      col       <= '0;
      px        <= '0;
      py        <= '0;
    end else if (state == IDLE && row_valid) begin
      row_q     <= node_flat;
      row_idx_q <= row_index;
      col       <= '0;
      px        <= '0;
      py        <= '0;
    end else if (adv) begin
      if (px == LAST_PX) begin
        px <= '0;
        if (py == LAST_PY) begin
          py  <= '0;
          col <= (col == LAST_COL) ? '0 : col + 10'd1;
        end else begin
          py <= py + 10'd1;
        end
      end else begin
        px <= px + 10'd1;
      end
    end
  end

  // Only the sign, integer and top 8 fraction bits of the amplitude matter.
  assign amp = row_q[32*col + 19 +: 13];

  always_comb begin
    if (amp[31])           idx = '0;
    else if (|amp[30:27])  idx = '1;
    else                   idx = amp[26:19];
  end

  assign color = {idx[7:5],
                  idx[7] ? ~idx[6:4] : idx[6:4],
                  idx[7] ? 2'b00     : ~idx[6:5]};

  // Pixel outputs are forced to zero outside PAINT so the idle port is quiet.
  assign pix_x     = (state == PAINT) ? 10'(X_OFFSET) + col * 10'(CELL_W) + px : '0;
  assign pix_y     = (state == PAINT) ? 10'(Y_OFFSET) + 10'(row_idx_q) * 10'(CELL_H) + py : '0;
  assign pix_color = (state == PAINT) ? color : '0;

endmodule

// File: tb/tb_heat_row_painter.sv
// Randomised bench for heat_row_painter: each painted pixel is checked against
// a model that enumerates the expected scan order and heat colour arithmetically.
module tb_heat_row_painter;

  localparam int N_COLS = 30;
  localparam int CELL_W = 8;
  localparam int CELL_H = 8;
  localparam int NPIX   = N_COLS * CELL_W * CELL_H;

  logic                  clk_50 = 1'b0;
  logic                  reset;
  logic                  row_valid;
  logic [7:0]            row_index;
  logic [7:0]            height;
  logic [32*N_COLS-1:0]  node_flat;
  logic                  row_ready;
  logic                  pix_we;
  logic [9:0]            pix_x;
  logic [9:0]            pix_y;
  logic [7:0]            pix_color;
  logic                  pix_ack;
  logic                  frame_done;

  heat_row_painter #(
    .N_COLS(N_COLS), .CELL_W(CELL_W), .CELL_H(CELL_H), .X_OFFSET(0), .Y_OFFSET(0)
  ) dut (
    .clk_50(clk_50), .reset(reset), .row_valid(row_valid), .row_index(row_index),
    .height(height), .node_flat(node_flat), .row_ready(row_ready), .pix_we(pix_we),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_ack(pix_ack),
    .frame_done(frame_done)
  );

  always #10 clk_50 = ~clk_50;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: the row as the painter should have latched it.
  int mrow [N_COLS];
  int mrow_idx;

  function automatic int heat(input int v);
    int i, r, g, b;
    if (v < 0)               i = 0;
    else if (v >= (1 << 27)) i = 255;
    else                     i = v / (1 << 19);
    r = i / 32;
    if (i >= 128) begin
      g = 7 - (i / 16) % 8;
      b = 0;
    end else begin
      g = (i / 16) % 8;
      b = 3 - (i / 32) % 4;
    end
    return r * 32 + g * 4 + b;
  endfunction

  function automatic logic [30:0] expect_pix(input int k);
    int c, rem, x, y;
    c   = k / (CELL_W * CELL_H);
    rem = k % (CELL_W * CELL_H);
    x   = (c * CELL_W + rem % CELL_W) % 1024;
    y   = (mrow_idx * CELL_H + rem / CELL_W) % 1024;
    return {1'b1, 1'b0, 1'b0, 10'(x), 10'(y), 8'(heat(mrow[c]))};
  endfunction

  function automatic logic [30:0] observed();
    return {pix_we, frame_done, row_ready, pix_x, pix_y, pix_color};
  endfunction

  task automatic rand_row();
    for (int i = 0; i < N_COLS; i++) begin
      case ($urandom_range(0, 3))
        0: mrow[i] = int'($urandom);
        1: mrow[i] = int'($urandom_range(0, (1 << 27) - 1));
        2: mrow[i] = -int'($urandom_range(1, 1 << 27));
        default: mrow[i] = (1 << 27) - 1 + int'($urandom_range(0, 2));
      endcase
    end
  endtask

  task automatic send_row(input int idx, input int hgt);
    for (int i = 0; i < N_COLS; i++) node_flat[32*i +: 32] = mrow[i];
    row_index = 8'(idx);
    height    = 8'(hgt);
    mrow_idx  = idx;
    @(negedge clk_50);
    row_valid = 1'b1;
    @(posedge clk_50);
    #1 row_valid = 1'b0;
  endtask

  // mode 0: ack always; 1: ack pattern 1,0,0 with a stray row_valid; 2: random ack
  task automatic paint(input int stop_after, input int mode, input bit exp_fd, output int cycles);
    int n;
    bit ack;
    n = 0;
    cycles = 0;
    while (n < stop_after && cycles < 20000) begin
      @(negedge clk_50);
      cycles++;
      check("pixel", {1'b0, observed()}, {1'b0, expect_pix(n)});
      case (mode)
        0:       ack = 1'b1;
        1:       ack = (cycles % 3 == 1);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && cycles == 40) begin
        row_valid = 1'b1;
        row_index = 8'(mrow_idx + 1);
        node_flat = {N_COLS{32'($urandom)}};
      end
      if (cycles == 41) row_valid = 1'b0;
      pix_ack = ack;
      if (ack) n++;
    end
    check("acked_writes", n, stop_after);
    if (stop_after == NPIX) begin
      @(negedge clk_50);
      pix_ack = (mode == 0);
      check("finish_cycle", {pix_we, frame_done, row_ready}, {1'b0, exp_fd, 1'b0});
      @(negedge clk_50);
      check("back_to_idle", {pix_we, frame_done, row_ready}, 3'b001);
    end
  endtask

  initial begin
    int cyc;
    int idx, hgt;
    reset     = 1'b1;
    row_valid = 1'b0;
    pix_ack   = 1'b0;
    node_flat = '0;
    row_index = '0;
    height    = '0;
    repeat (3) @(negedge clk_50);
    check("reset_state", {1'b0, observed()}, {1'b0, 1'b0, 1'b0, 1'b1, 28'd0});
    reset = 1'b0;
    @(negedge clk_50);
    check("idle_after_reset", {1'b0, observed()}, {1'b0, 1'b0, 1'b0, 1'b1, 28'd0});

    // Ramp: column i carries i*2^22
    for (int i = 0; i < N_COLS; i++) mrow[i] = i << 22;
    send_row(2, 5);
    paint(NPIX, 0, 1'b0, cyc);
    check("ramp_write_cycles", cyc, NPIX);

    // Clamp boundaries: negative, exactly 1.0, zero
    rand_row();
    mrow[0] = int'(32'hF800_0000);
    mrow[1] = int'(32'h0800_0000);
    mrow[2] = 0;
    send_row(7, 5);
    paint(NPIX, 2, 1'b0, cyc);

    // Back-pressure 1,0,0 with an ignored row_valid mid-row
    rand_row();
    send_row(11, 5);
    paint(NPIX, 1, 1'b0, cyc);
    check("bp_write_cycles", cyc, 3 * (NPIX - 1) + 1);
    pix_ack = 1'b0;

    // Last grid row raises frame_done
    rand_row();
    send_row(29, 29);
    paint(NPIX, 0, 1'b1, cyc);

    // Random rows, including pix_y wrap for large row indices
    repeat (2) begin
      rand_row();
      idx = int'($urandom_range(0, 255));
      hgt = ($urandom_range(0, 1) == 1) ? idx : int'($urandom_range(0, 255));
      send_row(idx, hgt);
      paint(NPIX, 2, (idx == hgt), cyc);
    end

    // Asynchronous reset in the middle of a row
    rand_row();
    send_row(4, 5);
    paint(100, 0, 1'b0, cyc);
    @(posedge clk_50);
    #3 reset = 1'b1;
    #1 check("async_reset_drop", {pix_we, row_ready}, 2'b01);
    @(negedge clk_50);
    reset   = 1'b0;
    pix_ack = 1'b0;
    rand_row();
    send_row(9, 5);
    paint(NPIX, 2, 1'b0, cyc);

    // Reset asserted together with row_valid wins
    @(negedge clk_50);
    reset     = 1'b1;
    row_valid = 1'b1;
    @(negedge clk_50);
    reset     = 1'b0;
    row_valid = 1'b0;
    @(negedge clk_50);
    check("reset_beats_row_valid", {pix_we, frame_done, row_ready}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
